ctrl_pipe_hazard: RTL

//  Consumer of control_unit decode outputs: carries the D-stage control word through the E/M/W

---
 rtl/ctrl_pipe_hazard_pkg.sv | 30 +++
 rtl/ctrl_pipe_hazard_stage.sv | 35 +++
 rtl/ctrl_pipe_hazard.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ctrl_pipe_hazard_pkg.sv
// Shared control-word type, result-select and forwarding encodings for ctrl_pipe_hazard.
package ctrl_pipe_hazard_pkg;

  localparam int unsigned CTRL_ALUCTL_W = 3;

  typedef enum logic [1:0] {
    RESULTSRC_ALU  = 2'b00,
    RESULTSRC_LOAD = 2'b01,
    RESULTSRC_PC4  = 2'b10
  } resultsrc_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_t;

  typedef struct packed {
    logic                     regwrite;
    logic [1:0]               resultsrc;
    logic                     memwrite;
    logic                     jump;
    logic                     branch;
    logic [CTRL_ALUCTL_W-1:0] alucontrol;
    logic                     alusrc;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_pipe_hazard_stage.sv
// Pipeline register bank: async clear to zero, synchronous flush loads BUBBLE.
module ctrl_stage_reg
  import ctrl_pipe_hazard_pkg::*;
#(
  parameter int unsigned   W      = 1,
  parameter logic [W-1:0]  BUBBLE = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  always_comb begin
    data_d = d;
    if (flush) begin
      data_d = BUBBLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// E/M/W control pipeline with load-use stall, redirect flush and forwarding select.
// Optional macro CTRL_FORWARD_EN enables M/W forwarding; without it RAW hazards stall.
module ctrl_pipe_hazard
  import ctrl_pipe_hazard_pkg::*;
#(
  parameter int unsigned RA_W     = 5,
  parameter int unsigned ALUCTL_W = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                regwrite_d,
  input  logic [1:0]          resultsrc_d,
  input  logic                memwrite_d,
  input  logic                jump_d,
  input  logic                branch_d,
  input  logic [ALUCTL_W-1:0] alucontrol_d,
  input  logic                alusrc_d,
  input  logic [RA_W-1:0]     rs1_d,
  input  logic [RA_W-1:0]     rs2_d,
  input  logic [RA_W-1:0]     rd_d,
  input  logic                zero_e,
  output logic [ALUCTL_W-1:0] alucontrol_e,
  output logic                alusrc_e,
  output logic                pcsrc_e,
  output logic                memwrite_m,
  output logic                regwrite_m,
  output logic [RA_W-1:0]     rd_m,
  output logic                regwrite_w,
  output logic [1:0]          resultsrc_w,
  output logic [RA_W-1:0]     rd_w,
  output logic                stall_f,
  output logic                stall_d,
  output logic                flush_d,
  output logic [1:0]          forward_a_e,
  output logic [1:0]          forward_b_e,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam int unsigned CW_W = $bits(ctrl_word_t);
`ifdef CTRL_FORWARD_EN
  localparam int unsigned DE_W = CW_W + 3 * RA_W;
`else
  localparam int unsigned DE_W = CW_W + RA_W;
`endif
  localparam int unsigned EM_W = 4 + RA_W;
  localparam int unsigned MW_W = 3 + RA_W;

  ctrl_word_t       cw_d;
  ctrl_word_t       cw_e;
  logic [RA_W-1:0]  rd_e;
  logic [DE_W-1:0]  de_d;
  logic [DE_W-1:0]  de_q;
  logic [EM_W-1:0]  em_q;
  logic [MW_W-1:0]  mw_q;
  logic [1:0]       resultsrc_m;
  logic             hz;
  logic             flush_e;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;

  always_comb begin
    cw_d = '{regwrite:   regwrite_d,
             resultsrc:  resultsrc_d,
             memwrite:   memwrite_d,
             jump:       jump_d,
             branch:     branch_d,
             alucontrol: CTRL_ALUCTL_W'(alucontrol_d),
             alusrc:     alusrc_d};
  end

`ifdef CTRL_FORWARD_EN
  logic [RA_W-1:0] rs1_e;
  logic [RA_W-1:0] rs2_e;
  assign de_d = {cw_d, rd_d, rs1_d, rs2_d};
  assign {cw_e, rd_e, rs1_e, rs2_e} = de_q;
`else
  assign de_d = {cw_d, rd_d};
  assign {cw_e, rd_e} = de_q;
`endif

  ctrl_stage_reg #(
    .W      (DE_W),
    .BUBBLE ({CTRL_BUBBLE, {(DE_W - CW_W){1'b0}}})
  ) u_de (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush_e),
    .d     (de_d),
    .q     (de_q)
  );

  ctrl_stage_reg #(
    .W      (EM_W),
    .BUBBLE ('0)
  ) u_em (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (1'b0),
    .d     ({cw_e.regwrite, cw_e.resultsrc, cw_e.memwrite, rd_e}),
    .q     (em_q)
  );

  assign {regwrite_m, resultsrc_m, memwrite_m, rd_m} = em_q;

  ctrl_stage_reg #(
    .W      (MW_W),
    .BUBBLE ('0)
  ) u_mw (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (1'b0),
    .d     ({regwrite_m, resultsrc_m, rd_m}),
    .q     (mw_q)
  );

  assign {regwrite_w, resultsrc_w, rd_w} = mw_q;

  assign alucontrol_e = ALUCTL_W'(cw_e.alucontrol);
  assign alusrc_e     = cw_e.alusrc;
  assign pcsrc_e      = cw_e.jump | (cw_e.branch & zero_e);

`ifdef CTRL_FORWARD_EN
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs,
                                         input logic rw_m, input logic [RA_W-1:0] dst_m,
                                         input logic rw_w, input logic [RA_W-1:0] dst_w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (rw_m && (dst_m != '0) && (dst_m == rs)) begin
      sel = FWD_M;
    end else if (rw_w && (dst_w != '0) && (dst_w == rs)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

  always_comb begin
    hz = (cw_e.resultsrc == RESULTSRC_LOAD) && (rd_e != '0) &&
         ((rd_e == rs1_d) || (rd_e == rs2_d));
    forward_a_e = fwd_sel(rs1_e, regwrite_m, rd_m, regwrite_w, rd_w);
    forward_b_e = fwd_sel(rs2_e, regwrite_m, rd_m, regwrite_w, rd_w);
  end
`else
  // W writes the regfile in the first half-cycle, so only E and M producers stall.
  always_comb begin
    hz = ((rs1_d != '0) && ((cw_e.regwrite && (rd_e == rs1_d)) ||
                            (regwrite_m && (rd_m == rs1_d)))) ||
         ((rs2_d != '0) && ((cw_e.regwrite && (rd_e == rs2_d)) ||
                            (regwrite_m && (rd_m == rs2_d))));
    forward_a_e = FWD_RF;
    forward_b_e = FWD_RF;
  end
`endif

  assign stall_f = hz & ~pcsrc_e;
  assign stall_d = hz & ~pcsrc_e;
  assign flush_d = pcsrc_e;
  assign flush_e = pcsrc_e | stall_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_d && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
